axis_rgb2gray_pipe: RTL and testbench
=====================================

Name: axis_rgb2gray_pipe

Overview:
Parametrised AXI4-Stream RGB-to-greyscale converter for the edge-detection video path. It sits between the video source and the filter stages.
- Selectable conversion mode; the mode is latched only at start-of-frame.
- Two-stage pipeline with full tvalid/tready backpressure.
- Sideband (tuser = SOF, tlast = EOL) is carried aligned with the data.

Parameters:
CH_W, 8, bits per colour channel; bus is 3*CH_W wide, R in the MSB field, then G, then B in the LSB field.
MODE_RST, 0, mode in effect after reset until the first SOF beat is accepted.

Ports:
aclk  in  1  clock; all logic on rising edge.
aresetn  in  1  asynchronous, active-low reset.
cfg_mode  in  2  0 = average, 1 = BT.601 luma, 2 = passthrough, 3 = green only.
s_axis_tvalid  in  1  input beat valid.
s_axis_tdata  in  3*CH_W  {R,G,B} pixel.
s_axis_tready  out  1  input accepted when tvalid & tready.
s_axis_tuser  in  1  start of frame.
s_axis_tlast  in  1  end of line.
m_axis_tvalid  out  1  output beat valid.
m_axis_tdata  out  3*CH_W  {Y,Y,Y}, or the pixel unchanged in passthrough.
m_axis_tready  in  1  downstream ready.
m_axis_tuser  out  1  SOF, aligned with the data.
m_axis_tlast  out  1  EOL, aligned with the data.

Behaviour:
Reset:
- Async assert clears v1, v2, m_axis_tvalid, m_axis_tdata, m_axis_tuser and m_axis_tlast to 0.
- active_mode resets to MODE_RST.
- Reset mid-frame discards all in-flight beats; none are replayed.

Pipeline:
- Stage 1 registers the per-channel products and sideband.
- Stage 2 registers the sum, rounding and saturation. Stage 2 drives the m_axis outputs.
- Stage k loads when !v_k or when stage k+1 is accepting; the output stage accepts when !v2 or m_axis_tready.
- s_axis_tready = !v1 | !v2 | m_axis_tready. This is combinational from m_axis_tready.
- Latency is exactly 2 cycles from input acceptance to m_axis_tvalid when unstalled; throughput is 1 beat/cycle.
- No bubbles are inserted; no beats are dropped or duplicated under any tready pattern.
- While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tuser and m_axis_tlast hold stable.

Mode latching:
- On an accepted beat with s_axis_tuser=1, active_mode <= cfg_mode, and that beat already uses the new mode.
- cfg_mode changes mid-frame are ignored until the next SOF.
- Each beat carries its mode through the pipeline, so a mode change never affects beats already in flight.

Arithmetic (unsigned, full precision internally):
- average: Y = floor((R+G+B)/3), exact for every input value.
- luma: Y = (77R + 150G + 29B + 2^(CH_W-1)) >> 8 for CH_W=8; the coefficients scale identically for other widths. Saturate at 2^CH_W-1.
- green: Y = G.
- passthrough: tdata is forwarded unchanged.
- The result is never wider than CH_W and never wraps.

Sideband:
- tuser and tlast pass through untouched, including tuser and tlast set on the same beat.
- The block does not check line length.

Optional Feature:
AXIS_R2G_SKID_EN
- Defined: a 2-entry skid buffer sits on the input, so s_axis_tready is driven directly from a flop. There is no combinational m_axis_tready to s_axis_tready path. Latency becomes 3 cycles; throughput stays 1 beat/cycle.
- Undefined: behaviour is as described above (combinational ready, 2-cycle latency).

Decomposition:
- Shared package axis_video_pkg holds:
  - the mode enum (MODE_AVG, MODE_LUMA, MODE_PASS, MODE_GREEN);
  - the luma coefficient constants 77, 150 and 29, and the shift of 8;
  - a pixel struct {r,g,b} parametrised by CH_W.
- One natural sub-module, axis_skid_buf (2-entry, generic width), instantiated only under AXIS_R2G_SKID_EN.

Test Plan:
1. Reset; SOF beat with cfg_mode=0, tdata=0x0A141E, m_axis_tready=1 -> two cycles later m_axis_tdata=0x141414, tuser=1.
2. cfg_mode=1, SOF pixel 0xFFFFFF then 0xFF0000 -> outputs 0xFFFFFF, then 0x4D4D4D.
3. Line of 4 beats in mode 0; cfg_mode changed to 1 after beat 2 without SOF -> all 4 outputs computed with average; next SOF beat uses luma.
4. m_axis_tready toggled randomly 50% over 1000 beats with random s_axis_tvalid -> output sequence equals the reference model in order, no loss or duplication, data stable while stalled.
5. Assert aresetn low with 2 beats in flight -> m_axis_tvalid=0 immediately; after release the first output is the next accepted input only.
6. Passthrough mode, tuser and tlast set on the same beat 0x123456 -> output 0x123456 with tuser=1 and tlast=1; repeat with AXIS_R2G_SKID_EN defined -> latency 3 and s_axis_tready flop-driven.

Source files
------------

// File: rtl/axis_video_pkg.sv
// Shared video-stream definitions: conversion modes, BT.601 luma
// coefficients and a default-width {r,g,b} pixel layout.
// Modules with a non-default channel width declare the same pixel
// layout locally, sized by their own CH_W parameter.
package axis_video_pkg;

  typedef enum logic [1:0] {
    MODE_AVG   = 2'd0,
    MODE_LUMA  = 2'd1,
    MODE_PASS  = 2'd2,
    MODE_GREEN = 2'd3
  } mode_e;

  // BT.601 luma weights in 1/256 units
  localparam int unsigned LUMA_CR    = 77;
  localparam int unsigned LUMA_CG    = 150;
  localparam int unsigned LUMA_CB    = 29;
  localparam int unsigned LUMA_SHIFT = 8;
  localparam int unsigned LUMA_RND   = 1 << (LUMA_SHIFT - 1);

  localparam int unsigned PIX_CH_W = 8;

  // R in the MSB field, B in the LSB field
  typedef struct packed {
    logic [PIX_CH_W-1:0] r;
    logic [PIX_CH_W-1:0] g;
    logic [PIX_CH_W-1:0] b;
  } pixel_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer for a valid/ready stream of generic width.
// s_ready_o comes straight from a flop, so there is no combinational
// path from m_ready_i back to s_ready_o.
// Ports: clk, rst_n (async, active-low); s_valid_i/s_data_i/s_ready_o
// upstream; m_valid_o/m_data_o/m_ready_i downstream.
module axis_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid_i,
  input  logic [W-1:0] s_data_i,
  output logic         s_ready_o,
  output logic         m_valid_o,
  output logic [W-1:0] m_data_o,
  input  logic         m_ready_i
);

  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  logic         ready_q, ready_d;
  logic         in_fire_c;

  assign in_fire_c = s_valid_i & ready_q;

  // Main entry refills from the skid entry first so ordering is kept
  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (!main_v_q || m_ready_i) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = in_fire_c;
        if (in_fire_c) main_d = s_data_i;
      end
    end else if (in_fire_c) begin
      skid_d   = s_data_i;
      skid_v_d = 1'b1;
    end
    ready_d = !skid_v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      main_v_q <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      main_q   <= main_d;
      main_v_q <= main_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      ready_q  <= ready_d;
    end
  end

  assign s_ready_o = ready_q;
  assign m_valid_o = main_v_q;
  assign m_data_o  = main_q;

endmodule

// File: rtl/axis_rgb2gray_pipe.sv
// AXI4-Stream RGB to greyscale converter, two register stages with full
// backpressure. Stage 1 holds per-channel products, stage 2 holds the
// rounded/saturated result and drives the master port.
// Build option AXIS_R2G_SKID_EN: inserts axis_skid_buf on the input so
// s_axis_tready is flop-driven (latency 3 instead of 2).
// Ports: aclk, aresetn (async, active-low); cfg_mode (mode, latched on
// accepted SOF); s_axis_* slave stream; m_axis_* master stream.
module axis_rgb2gray_pipe
  import axis_video_pkg::*;
#(
  parameter int unsigned CH_W     = 8,
  parameter int unsigned MODE_RST = 0
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [1:0]        cfg_mode,
  input  logic              s_axis_tvalid,
  input  logic [3*CH_W-1:0] s_axis_tdata,
  output logic              s_axis_tready,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  output logic [3*CH_W-1:0] m_axis_tdata,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast
);

  localparam int unsigned PIX_W  = 3 * CH_W;
  localparam int unsigned PROD_W = CH_W + LUMA_SHIFT;
  localparam int unsigned SUM_W  = PROD_W + 2;
  localparam int unsigned BEAT_W = PIX_W + 4;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } pix_t;

  // A beat carries its own mode so later mode changes never touch it
  typedef struct packed {
    mode_e mode;
    logic  user;
    logic  last;
    pix_t  pix;
  } beat_t;

  function automatic logic [CH_W-1:0] sat(input logic [SUM_W-1:0] v);
    return (|v[SUM_W-1:CH_W]) ? '1 : v[CH_W-1:0];
  endfunction

  mode_e              active_mode_q, active_mode_d;
  beat_t              in_beat_c;
  logic               in_fire_c;
  logic               p_valid_c;
  beat_t              p_beat_c;
  logic               load1_c, load2_c;

  logic               v1_q, v1_d;
  mode_e              s1_mode_q, s1_mode_d;
  logic               s1_user_q, s1_user_d;
  logic               s1_last_q, s1_last_d;
  pix_t               s1_pix_q, s1_pix_d;
  logic [PROD_W-1:0]  s1_pr_q, s1_pr_d;
  logic [PROD_W-1:0]  s1_pg_q, s1_pg_d;
  logic [PROD_W-1:0]  s1_pb_q, s1_pb_d;

  logic               v2_q, v2_d;
  logic [PIX_W-1:0]   tdata_q, tdata_d;
  logic               tuser_q, tuser_d;
  logic               tlast_q, tlast_d;

  logic [SUM_W-1:0]   sum_c, avg_c, luma_c;
  logic [CH_W-1:0]    y_c;

  // SOF beat takes the new mode immediately
  always_comb begin
    in_beat_c.mode = s_axis_tuser ? mode_e'(cfg_mode) : active_mode_q;
    in_beat_c.user = s_axis_tuser;
    in_beat_c.last = s_axis_tlast;
    in_beat_c.pix  = pix_t'(s_axis_tdata);
  end

  assign in_fire_c = s_axis_tvalid & s_axis_tready;

  always_comb begin
    active_mode_d = active_mode_q;
    if (in_fire_c && s_axis_tuser) active_mode_d = mode_e'(cfg_mode);
  end

  assign load2_c = !v2_q | m_axis_tready;
  assign load1_c = !v1_q | load2_c;

`ifdef AXIS_R2G_SKID_EN
  logic [BEAT_W-1:0] skid_in_c;
  logic [BEAT_W-1:0] skid_out_c;

  assign skid_in_c = in_beat_c;
  assign p_beat_c  = beat_t'(skid_out_c);

  axis_skid_buf #(.W(BEAT_W)) u_skid (
    .clk       (aclk),
    .rst_n     (aresetn),
    .s_valid_i (s_axis_tvalid),
    .s_data_i  (skid_in_c),
    .s_ready_o (s_axis_tready),
    .m_valid_o (p_valid_c),
    .m_data_o  (skid_out_c),
    .m_ready_i (load1_c)
  );
`else
  assign p_valid_c     = s_axis_tvalid;
  assign p_beat_c      = in_beat_c;
  assign s_axis_tready = load1_c;
`endif

  // Stage 1: products; average mode uses unit weights so stage 2 shares the adder
  always_comb begin
    v1_d      = v1_q;
    s1_mode_d = s1_mode_q;
    s1_user_d = s1_user_q;
    s1_last_d = s1_last_q;
    s1_pix_d  = s1_pix_q;
    s1_pr_d   = s1_pr_q;
    s1_pg_d   = s1_pg_q;
    s1_pb_d   = s1_pb_q;
    if (load1_c) begin
      v1_d = p_valid_c;
      if (p_valid_c) begin
        s1_mode_d = p_beat_c.mode;
        s1_user_d = p_beat_c.user;
        s1_last_d = p_beat_c.last;
        s1_pix_d  = p_beat_c.pix;
        if (p_beat_c.mode == MODE_AVG) begin
          s1_pr_d = PROD_W'(p_beat_c.pix.r);
          s1_pg_d = PROD_W'(p_beat_c.pix.g);
          s1_pb_d = PROD_W'(p_beat_c.pix.b);
        end else begin
          s1_pr_d = PROD_W'(LUMA_CR) * PROD_W'(p_beat_c.pix.r);
          s1_pg_d = PROD_W'(LUMA_CG) * PROD_W'(p_beat_c.pix.g);
          s1_pb_d = PROD_W'(LUMA_CB) * PROD_W'(p_beat_c.pix.b);
        end
      end
    end
  end

  // Stage 2 arithmetic: exact divide-by-3 for average, rounded shift for luma
  always_comb begin
    sum_c  = SUM_W'(s1_pr_q) + SUM_W'(s1_pg_q) + SUM_W'(s1_pb_q);
    avg_c  = sum_c / SUM_W'(3);
    luma_c = (sum_c + SUM_W'(LUMA_RND)) >> LUMA_SHIFT;
    case (s1_mode_q)
      MODE_AVG:   y_c = sat(avg_c);
      MODE_LUMA:  y_c = sat(luma_c);
      MODE_GREEN: y_c = s1_pix_q.g;
      default:    y_c = s1_pix_q.g;
    endcase
  end

  // Stage 2 register load; outputs hold while stalled
  always_comb begin
    v2_d    = v2_q;
    tdata_d = tdata_q;
    tuser_d = tuser_q;
    tlast_d = tlast_q;
    if (load2_c) begin
      v2_d = v1_q;
      if (v1_q) begin
        tdata_d = (s1_mode_q == MODE_PASS) ? PIX_W'(s1_pix_q) : {y_c, y_c, y_c};
        tuser_d = s1_user_q;
        tlast_d = s1_last_q;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      active_mode_q <= mode_e'(2'(MODE_RST));
      v1_q          <= 1'b0;
      s1_mode_q     <= MODE_AVG;
      s1_user_q     <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_pix_q      <= '0;
      s1_pr_q       <= '0;
      s1_pg_q       <= '0;
      s1_pb_q       <= '0;
      v2_q          <= 1'b0;
      tdata_q       <= '0;
      tuser_q       <= 1'b0;
      tlast_q       <= 1'b0;
    end else begin
      active_mode_q <= active_mode_d;
      v1_q          <= v1_d;
      s1_mode_q     <= s1_mode_d;
      s1_user_q     <= s1_user_d;
      s1_last_q     <= s1_last_d;
      s1_pix_q      <= s1_pix_d;
      s1_pr_q       <= s1_pr_d;
      s1_pg_q       <= s1_pg_d;
      s1_pb_q       <= s1_pb_d;
      v2_q          <= v2_d;
      tdata_q       <= tdata_d;
      tuser_q       <= tuser_d;
      tlast_q       <= tlast_d;
    end
  end

  assign m_axis_tvalid = v2_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_rgb2gray_pipe.sv
// Bench for axis_rgb2gray_pipe: fixed vectors with exact-latency checks,
// a mode-latching line sequence, randomized backpressure against a
// scoreboard, and reset with beats in flight.
module tb_axis_rgb2gray_pipe;

`ifdef AXIS_R2G_SKID_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        aclk;
  logic        aresetn;
  logic [1:0]  cfg_mode;
  logic        s_valid, s_ready, s_user, s_last;
  logic [23:0] s_data;
  logic        m_valid, m_ready, m_user, m_last;
  logic [23:0] m_data;

  axis_rgb2gray_pipe #(.CH_W(8), .MODE_RST(0)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_mode      (cfg_mode),
    .s_axis_tvalid (s_valid),
    .s_axis_tdata  (s_data),
    .s_axis_tready (s_ready),
    .s_axis_tuser  (s_user),
    .s_axis_tlast  (s_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tdata  (m_data),
    .m_axis_tready (m_ready),
    .m_axis_tuser  (m_user),
    .m_axis_tlast  (m_last)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int total = 0;
  int bad   = 0;

  logic [25:0] exp_q[$];
  logic [23:0] got_q[$];
  logic [1:0]  mdl_mode = 2'd0;
  logic        prev_stall = 1'b0;
  logic [25:0] prev_out = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  // Greyscale value straight from the arithmetic definitions
  function automatic logic [23:0] ref_out(input logic [1:0] mode, input logic [23:0] pix);
    int r, g, b, y;
    r = int'(pix[23:16]);
    g = int'(pix[15:8]);
    b = int'(pix[7:0]);
    case (mode)
      2'd0: y = (r + g + b) / 3;
      2'd1: begin
        y = (77 * r + 150 * g + 29 * b + 128) / 256;
        if (y > 255) y = 255;
      end
      2'd3: y = g;
      default: return pix;
    endcase
    return {y[7:0], y[7:0], y[7:0]};
  endfunction

  // Scoreboard: accepted inputs become expected outputs; stalled outputs must hold
  initial forever begin
    @(negedge aclk);
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_hold", 32'({m_user, m_last, m_data}), 32'(prev_out));
      end
      if (s_valid && s_ready) begin
        if (s_user) mdl_mode = cfg_mode;
        exp_q.push_back({s_user, s_last, ref_out(mdl_mode, s_data)});
      end
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0)
          chk("out_beat", 32'({m_user, m_last, m_data}), 32'(exp_q.pop_front()));
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_user, m_last, m_data};
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        user;
    logic        last;
    logic [23:0] pix;
    logic [23:0] want;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int acc, cyc, w;
    logic hs;

    vecs[0]  = '{2'd0, 1'b1, 1'b0, 24'h0A141E, 24'h141414};
    vecs[1]  = '{2'd1, 1'b1, 1'b0, 24'hFFFFFF, 24'hFFFFFF};
    vecs[2]  = '{2'd1, 1'b0, 1'b0, 24'hFF0000, 24'h4D4D4D};
    vecs[3]  = '{2'd2, 1'b1, 1'b1, 24'h123456, 24'h123456};
    vecs[4]  = '{2'd3, 1'b1, 1'b0, 24'h10AB20, 24'hABABAB};
    vecs[5]  = '{2'd0, 1'b1, 1'b0, 24'hFFFFFF, 24'hFFFFFF};
    vecs[6]  = '{2'd0, 1'b0, 1'b0, 24'h010000, 24'h000000};
    vecs[7]  = '{2'd0, 1'b0, 1'b1, 24'h020100, 24'h010101};
    vecs[8]  = '{2'd1, 1'b0, 1'b0, 24'h00FF00, 24'h555555};
    vecs[9]  = '{2'd1, 1'b1, 1'b0, 24'h00FF00, 24'h959595};
    vecs[10] = '{2'd1, 1'b0, 1'b0, 24'h0000FF, 24'h1D1D1D};
    vecs[11] = '{2'd3, 1'b0, 1'b0, 24'h102030, 24'h1D1D1D};

    aresetn  = 1'b0;
    cfg_mode = 2'd0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_user   = 1'b0;
    s_last   = 1'b0;
    m_ready  = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_user", 32'(m_user), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    aresetn = 1'b1;
    tick();
    chk("idle_ready", 32'(s_ready), 32'd1);

    // Single isolated beats with exact latency
    foreach (vecs[i]) begin
      cfg_mode = vecs[i].mode;
      s_user   = vecs[i].user;
      s_last   = vecs[i].last;
      s_data   = vecs[i].pix;
      s_valid  = 1'b1;
      for (int c = 1; c < LAT; c++) begin
        tick();
        s_valid = 1'b0;
        s_user  = 1'b0;
        s_last  = 1'b0;
        chk($sformatf("v%0d_early", i), 32'(m_valid), 32'd0);
      end
      tick();
      chk($sformatf("v%0d_valid", i), 32'(m_valid), 32'd1);
      chk($sformatf("v%0d_data", i), 32'(m_data), 32'(vecs[i].want));
      chk($sformatf("v%0d_user", i), 32'(m_user), 32'(vecs[i].user));
      chk($sformatf("v%0d_last", i), 32'(m_last), 32'(vecs[i].last));
      tick();
    end

    // Line in average mode; mid-line cfg change ignored until next SOF
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      cfg_mode = (i < 2) ? 2'd0 : 2'd1;
      s_user   = (i == 0 || i == 4);
      s_last   = (i == 3);
      s_data   = 24'h00FF00;
      s_valid  = 1'b1;
      chk("seq_ready", 32'(s_ready), 32'd1);
      tick();
    end
    s_valid = 1'b0;
    s_user  = 1'b0;
    s_last  = 1'b0;
    repeat (LAT + 2) tick();
    chk("seq_count", 32'(got_q.size()), 32'd5);
    if (got_q.size() == 5) begin
      for (int i = 0; i < 4; i++) chk($sformatf("seq_avg%0d", i), 32'(got_q[i]), 32'h555555);
      chk("seq_luma_sof", 32'(got_q[4]), 32'h959595);
    end

    // Random valid/ready over 1000 accepted beats
    acc = 0;
    cyc = 0;
    hs  = 1'b0;
    s_valid = 1'b0;
    while (acc < 1000 && cyc < 20000) begin
      if (!s_valid || hs) begin
        s_valid = 1'($urandom % 2);
        s_data  = 24'($urandom);
        s_user  = ($urandom % 16) == 0;
        s_last  = ($urandom % 8) == 0;
      end
      cfg_mode = 2'($urandom % 4);
      m_ready  = 1'($urandom % 2);
      @(negedge aclk);
      hs = s_valid && s_ready;
      if (hs) acc++;
      tick();
      cyc++;
    end
    chk("rand_budget", 32'(acc >= 1000), 32'd1);
    s_valid = 1'b0;
    m_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      tick();
      w++;
    end
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    tick();

    // Reset with two beats in flight; nothing may reappear afterwards
    m_ready  = 1'b0;
    cfg_mode = 2'd0;
    s_user   = 1'b1;
    s_last   = 1'b0;
    s_data   = 24'h0A141E;
    s_valid  = 1'b1;
    tick();
    s_user = 1'b0;
    s_data = 24'h00FF00;
    tick();
    s_valid = 1'b0;
`ifdef AXIS_R2G_SKID_EN
    chk("skid_ready_full", 32'(s_ready), 32'd1);
    m_ready = 1'b1;
    #1;
    chk("skid_ready_flop", 32'(s_ready), 32'd1);
    m_ready = 1'b0;
    #1;
`else
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    chk("comb_ready_lo", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    #1;
    chk("comb_ready_hi", 32'(s_ready), 32'd1);
    m_ready = 1'b0;
    #1;
    chk("comb_ready_back", 32'(s_ready), 32'd0);
`endif
    aresetn = 1'b0;
    #1;
    chk("midrst_valid", 32'(m_valid), 32'd0);
    chk("midrst_ready", 32'(s_ready), 32'd1);
    exp_q.delete();
    got_q.delete();
    mdl_mode = 2'd0;
    tick();
    aresetn = 1'b1;
    m_ready = 1'b1;
    tick();
    cfg_mode = 2'd1;
    s_user   = 1'b1;
    s_data   = 24'h0000FF;
    s_valid  = 1'b1;
    tick();
    s_valid = 1'b0;
    s_user  = 1'b0;
    repeat (LAT + 2) tick();
    chk("post_rst_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("post_rst_first", 32'(got_q[0]), 32'h1D1D1D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
